bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Two-master burst arbiter sharing one 64-bit port of the dual-port frame BRAM (1024 x 64, byte-enabled, registered address, unregistered output). Sits between the camera line writer (m0) and the face-filter pixel reader (m1) and the BRAM s1 port. Grants whole bursts, generates incrementing BRAM addresses, and routes read data back with a readdatavalid tag.

## Interface
Parameters:
- ADDR_W, 10, BRAM word-address width.
- DATA_W, 64, data width.
- BE_W, 8, byteenable width (DATA_W/8).
- BURST_W, 5, burstcount width.
- MAX_BURST, 16, largest accepted burst length.

Ports:
- clk  in  1  single clock for arbiter and BRAM port.
- reset  in  1  synchronous, active-high.
- mN_address  in  ADDR_W  burst base word address (N = 0, 1).
- mN_burstcount  in  BURST_W  beats in burst.
- mN_read / mN_write  in  1  command strobes.
- mN_writedata  in  DATA_W  write beat data.
- mN_byteenable  in  BE_W  write beat byte lanes.
- mN_waitrequest  out  1  low = command/beat accepted this cycle.
- mN_readdata  out  DATA_W  read beat data.
- mN_readdatavalid  out  1  mN_readdata valid this cycle.
- bram_address  out  ADDR_W  BRAM port address.
- bram_chipselect  out  1  BRAM access this cycle.
- bram_write  out  1  BRAM write enable.
- bram_byteenable  out  BE_W  BRAM byte enables.
- bram_writedata  out  DATA_W  BRAM write data.
- bram_readdata  in  DATA_W  BRAM read data, valid 1 cycle after address.

## Operation
- States: IDLE, WRITE, READ. Registers: owner (1b), last_owner (1b), beat counter, remaining count, current address, rd_tag_valid, rd_tag_owner.
- IDLE: a master requests when read or write is high. Single requester is granted. Both requesting: grant the master that is not last_owner. Grant registers owner, base address, effective count; next state WRITE if write high, else READ. last_owner updates on grant. read and write both high: treated as write.
- Effective count: burstcount 0 -> 1; burstcount > MAX_BURST -> MAX_BURST.
- WRITE: owner's waitrequest low every cycle. Each cycle with owner write high is one beat: bram_chipselect = bram_write = 1, bram_address = base + beat index (mod 2^ADDR_W), writedata/byteenable passed through. Owner write low = bubble, no BRAM access, counter holds. After final beat -> IDLE.
- READ: owner's waitrequest low on the first READ cycle only (command accept). Arbiter issues one address per cycle, base + i mod 2^ADDR_W, i = 0..count-1, bram_chipselect = 1, bram_write = 0. After last address -> IDLE.
- Read return: each issued read sets rd_tag_valid/rd_tag_owner for next cycle; mN_readdatavalid = rd_tag_valid & (rd_tag_owner == N). mN_readdata = bram_readdata for both masters.
- Non-owner and all masters in IDLE see waitrequest = 1.
- Reset (any cycle, including mid-burst): state IDLE, last_owner = 1, rd_tag_valid = 0, both waitrequest = 1, both readdatavalid = 0, bram_chipselect = bram_write = 0, bram_address = 0. An in-flight read beat is dropped; a partial write burst is abandoned (already written beats remain in BRAM).

## Timing
- Arbitration: request seen in IDLE at cycle T -> grant state at T+1; no BRAM access in IDLE.
- Write burst of N beats, no bubbles: beats at T+1..T+N, IDLE at T+N+1.
- Read burst of N: addresses at T+1..T+N; readdatavalid at T+2..T+N+1 in order; IDLE at T+N+1; next grant's first access at T+N+2 earliest, so return data of different owners never collide.
- Throughput: one BRAM access per cycle inside a burst; one idle cycle between bursts.
- Combinational paths: owner-master write/writedata/byteenable -> bram_*; bram_readdata -> mN_readdata. All else registered.

## Configuration
- BRAM_ARB_FIXED_PRIO_EN: when defined, m0 (camera writer) wins every tie in IDLE; last_owner ignored. When undefined, round-robin as above.

## Test plan
- Single write: m0 writes burst 4 at 0x3FE, data D0..D3 -> BRAM writes at 0x3FE, 0x3FF, 0x000, 0x001 on cycles T+1..T+4; m1 waitrequest stays 1.
- Single read: m1 reads burst 3 at 0x010 after preload -> m1_readdatavalid at T+2..T+4 with words of 0x010..0x012; m0_readdatavalid never high.
- Contention: m0 and m1 request in same IDLE cycle after reset -> m0 granted first, m1 next; repeated back-to-back ties alternate m0, m1, m0 (with BRAM_ARB_FIXED_PRIO_EN: m0 every time, m1 served only when m0 idle).
- Burstcount edge: burstcount 0 -> exactly 1 access; burstcount 31 -> exactly 16 accesses.
- Write bubbles: m0 burst 4, write low on second cycle -> 4 BRAM writes over 5 cycles, addresses contiguous.
- Reset mid-read: reset asserted during beat 2 of an 8-beat read -> next cycle all outputs at reset values, no further readdatavalid, new request granted normally afterward.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Two-master burst arbiter in front of one 64-bit port of the frame BRAM.
//   m0 is the camera line writer and m1 is the face-filter pixel reader.
//   The arbiter grants whole bursts and generates incrementing word
//   addresses. Read data returns one cycle after the address and carries a
//   readdatavalid tag that identifies the owning master.
//
//   Build option: define BRAM_ARB_FIXED_PRIO_EN so that m0 wins every tie in
//   IDLE. When the macro is not defined, ties are resolved round-robin
//   against last_owner.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   mN_address/burstcount      burst base word address and beat count (N=0,1)
//   mN_read/write              command strobes (both high is taken as write)
//   mN_writedata/byteenable    write beat payload
//   mN_waitrequest             low = command/beat accepted this cycle
//   mN_readdata/readdatavalid  read return (the data bus is shared)
//   bram_*                     BRAM port (registered address, 1-cycle read)
module bram_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 64,
  parameter int BE_W      = 8,
  parameter int BURST_W   = 5,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  m0_address,
  input  logic [BURST_W-1:0] m0_burstcount,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [DATA_W-1:0]  m0_writedata,
  input  logic [BE_W-1:0]    m0_byteenable,
  output logic               m0_waitrequest,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic               m0_readdatavalid,
  input  logic [ADDR_W-1:0]  m1_address,
  input  logic [BURST_W-1:0] m1_burstcount,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [DATA_W-1:0]  m1_writedata,
  input  logic [BE_W-1:0]    m1_byteenable,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,
  output logic [ADDR_W-1:0]  bram_address,
  output logic               bram_chipselect,
  output logic               bram_write,
  output logic [BE_W-1:0]    bram_byteenable,
  output logic [DATA_W-1:0]  bram_writedata,
  input  logic [DATA_W-1:0]  bram_readdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t              state, state_nx;
  logic                owner, last_owner;
  logic                first_rd;      // first READ cycle: the command handshake
  logic [BURST_W-1:0]  remain;        // beats still to issue in this burst
  logic [ADDR_W-1:0]   cur_addr;      // address of the next beat
  logic                rd_tag_valid, rd_tag_owner;

  logic                req0, req1, any_req, win, win_wr, beat;
  logic [ADDR_W-1:0]   win_addr;
  logic [BURST_W-1:0]  win_bc, win_cnt;
  logic                o_write;
  logic [DATA_W-1:0]   o_wd;
  logic [BE_W-1:0]     o_be;
  logic                acc_ok;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign any_req = req0 | req1;

`ifdef BRAM_ARB_FIXED_PRIO_EN
  assign win = ~req0;
`else
  // On a tie, grant the master that did not own the previous burst.
  assign win = (req0 & req1) ? ~last_owner : req1;
`endif

  assign win_wr   = win ? m1_write      : m0_write;
  assign win_addr = win ? m1_address    : m0_address;
  assign win_bc   = win ? m1_burstcount : m0_burstcount;

  // A burstcount of 0 is treated as one beat. Longer requests are clamped.
  always_comb begin
    win_cnt = win_bc;
    if (win_bc == '0)
      win_cnt = BURST_W'(1);
    else if (win_bc > BURST_W'(MAX_BURST))
      win_cnt = BURST_W'(MAX_BURST);
  end

  // The write beat of the owner goes straight through to the BRAM port.
  assign o_write = owner ? m1_write      : m0_write;
  assign o_wd    = owner ? m1_writedata  : m0_writedata;
  assign o_be    = owner ? m1_byteenable : m0_byteenable;

  always_comb begin
    state_nx = state;
    beat     = 1'b0;
    case (state)
      IDLE:  if (any_req) state_nx = win_wr ? WRITE : READ;
      WRITE: if (o_write) begin
               beat = 1'b1;
               if (remain == BURST_W'(1)) state_nx = IDLE;
             end
      READ:  begin
               beat = 1'b1;
               if (remain == BURST_W'(1)) state_nx = IDLE;
             end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_owner   <= 1'b1;
      first_rd     <= 1'b0;
      remain       <= '0;
      cur_addr     <= '0;
      rd_tag_valid <= 1'b0;
      rd_tag_owner <= 1'b0;
    end else begin
      state        <= state_nx;
      rd_tag_valid <= (state == READ);
      rd_tag_owner <= owner;
      first_rd     <= 1'b0;
      if (state == IDLE && any_req) begin
        owner      <= win;
        last_owner <= win;
        cur_addr   <= win_addr;
        remain     <= win_cnt;
        first_rd   <= 1'b1;
      end else if (beat) begin
        cur_addr <= cur_addr + ADDR_W'(1);   // wraps mod 2^ADDR_W
        remain   <= remain - BURST_W'(1);
      end
    end
  end

  // A write owner may stream beats on any cycle. A read owner is acknowledged
  // only once, because the arbiter generates the remaining addresses itself.
  assign acc_ok = (state == WRITE) | ((state == READ) & first_rd);

  assign m0_waitrequest = ~(acc_ok & ~owner);
  assign m1_waitrequest = ~(acc_ok &  owner);

  assign bram_address    = cur_addr;
  assign bram_write      = (state == WRITE) & o_write;
  assign bram_chipselect = bram_write | (state == READ);
  assign bram_writedata  = o_wd;
  assign bram_byteenable = (state == WRITE) ? o_be :
                           (state == READ)  ? {BE_W{1'b1}} : '0;

  assign m0_readdata      = bram_readdata;
  assign m1_readdata      = bram_readdata;
  assign m0_readdatavalid = rd_tag_valid & ~rd_tag_owner;
  assign m1_readdatavalid = rd_tag_valid &  rd_tag_owner;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter. It contains a behavioural BRAM, a table of
// burst vectors, and hand-written sequences for timing, bubbles, contention
// and mid-burst reset. Expected BRAM accesses and read data go into queues
// when a burst is issued. A negedge monitor pops and compares them as the
// DUT produces them.
module tb_bram_port_arbiter;
  localparam int AW = 10, DW = 64, BW = 8, CW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] m_addr [2];
  logic [CW-1:0] m_bc   [2];
  logic          m_rd   [2];
  logic          m_wr   [2];
  logic [DW-1:0] m_wd   [2];
  logic [BW-1:0] m_be   [2];

  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic [AW-1:0] bram_address;
  logic          bram_chipselect, bram_write;
  logic [BW-1:0] bram_byteenable;
  logic [DW-1:0] bram_writedata;
  logic [DW-1:0] rd_q;

  bram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m_addr[0]), .m0_burstcount(m_bc[0]), .m0_read(m_rd[0]), .m0_write(m_wr[0]),
    .m0_writedata(m_wd[0]), .m0_byteenable(m_be[0]), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m_addr[1]), .m1_burstcount(m_bc[1]), .m1_read(m_rd[1]), .m1_write(m_wr[1]),
    .m1_writedata(m_wd[1]), .m1_byteenable(m_be[1]), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .bram_address(bram_address), .bram_chipselect(bram_chipselect), .bram_write(bram_write),
    .bram_byteenable(bram_byteenable), .bram_writedata(bram_writedata), .bram_readdata(rd_q)
  );

  // Behavioural BRAM: the address is registered and the read data appears
  // one cycle after the address.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (bram_chipselect) begin
      if (bram_write) begin
        for (int b = 0; b < BW; b++)
          if (bram_byteenable[b]) mem[bram_address][b*8 +: 8] <= bram_writedata[b*8 +: 8];
      end else begin
        rd_q <= mem[bram_address];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } acc_t;

  acc_t          accq [$];
  logic [DW-1:0] rdq0 [$];
  logic [DW-1:0] rdq1 [$];
  int            acc_log [$];
  int            rdv_log [$];
  int            wlow1;
  logic [DW-1:0] model_mem [1024];
  int            tests = 0, errors = 0;
  acc_t          mon_e;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] wdata(int tag, int i);
    return {16'(tag), 16'hBEEF ^ 16'(i), 16'(i * 3 + 1), 16'(tag * 7 + i)};
  endfunction

  function automatic logic wreq(int m);
    return (m != 0) ? m1_waitrequest : m0_waitrequest;
  endfunction

  // Queue the accesses and read data that a burst should produce, and keep
  // the shadow memory up to date.
  function automatic void exp_burst(int m, bit wr, logic [AW-1:0] a, int n,
                                    logic [BW-1:0] be, int tag);
    for (int i = 0; i < n; i++) begin
      acc_t e;
      logic [AW-1:0] ad;
      ad     = a + AW'(i);
      e.we   = wr;
      e.addr = ad;
      e.data = '0;
      e.be   = '0;
      if (wr) begin
        e.data = wdata(tag, i);
        e.be   = be;
        for (int b = 0; b < BW; b++)
          if (be[b]) model_mem[ad][b*8 +: 8] = e.data[b*8 +: 8];
      end else if (m == 0) rdq0.push_back(model_mem[ad]);
      else                 rdq1.push_back(model_mem[ad]);
      accq.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (bram_chipselect) begin
      acc_log.push_back(cyc);
      if (accq.size() == 0) begin
        tests++; errors++;
        $display("FAIL unexpected_access: addr %0h we %0b, none queued", bram_address, bram_write);
      end else begin
        mon_e = accq.pop_front();
        check("acc_we", 64'(bram_write), 64'(mon_e.we));
        check("acc_addr", 64'(bram_address), 64'(mon_e.addr));
        if (mon_e.we) begin
          check("acc_wdata", bram_writedata, mon_e.data);
          check("acc_be", 64'(bram_byteenable), 64'(mon_e.be));
        end
      end
    end
    if (m0_readdatavalid) begin
      if (rdq0.size() == 0) begin
        tests++; errors++;
        $display("FAIL unexpected_rdv0: data %0h", m0_readdata);
      end else check("rdata0", m0_readdata, rdq0.pop_front());
    end
    if (m1_readdatavalid) begin
      rdv_log.push_back(cyc);
      if (rdq1.size() == 0) begin
        tests++; errors++;
        $display("FAIL unexpected_rdv1: data %0h", m1_readdata);
      end else check("rdata1", m1_readdata, rdq1.pop_front());
    end
    if (!m1_waitrequest) wlow1++;
    if (!m0_waitrequest && !m1_waitrequest) begin
      tests++; errors++;
      $display("FAIL both_granted: both waitrequest low at cycle %0d", cyc);
    end
  end

  // Master driver. Call it just after a posedge. It returns just after the
  // posedge that follows the final accepted beat or command.
  task automatic master_burst(input int m, input bit wr, input logic [AW-1:0] a,
                              input logic [CW-1:0] bc, input logic [BW-1:0] be,
                              input int n, input int tag, input int bubble_at);
    int i = 0;
    int guard = 0;
    bit bub = 0;
    bit acc = 0;
    m_addr[m] = a; m_bc[m] = bc; m_be[m] = be;
    if (wr) begin
      m_wd[m] = wdata(tag, 0);
      m_wr[m] = 1'b1;
      while (i < n && guard < 200) begin
        @(negedge clk); guard++;
        if (!wreq(m)) i++;
        @(posedge clk); #1;
        if (i == bubble_at && !bub && i < n) begin
          m_wr[m] = 1'b0; bub = 1;
          @(posedge clk); #1;
          m_wr[m] = 1'b1;
        end
        m_wd[m] = wdata(tag, i);
      end
      m_wr[m] = 1'b0;
      acc = (i >= n);
    end else begin
      m_rd[m] = 1'b1;
      while (!acc && guard < 200) begin
        @(negedge clk); guard++;
        if (!wreq(m)) acc = 1;
        @(posedge clk); #1;
      end
      m_rd[m] = 1'b0;
    end
    if (!acc) begin
      tests++; errors++;
      $display("FAIL master%0d_timeout: burst at %0h not accepted", m, a);
    end
  endtask

  task automatic drain(input string nm);
    int g = 0;
    while ((accq.size() + rdq0.size() + rdq1.size()) != 0 && g < 100) begin
      @(posedge clk); #1; g++;
    end
    repeat (3) begin @(posedge clk); #1; end
    check({"drain_", nm}, 64'(accq.size() + rdq0.size() + rdq1.size()), 64'd0);
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_wait0"}, 64'(m0_waitrequest), 64'd1);
    check({nm, "_wait1"}, 64'(m1_waitrequest), 64'd1);
    check({nm, "_rdv0"}, 64'(m0_readdatavalid), 64'd0);
    check({nm, "_rdv1"}, 64'(m1_readdatavalid), 64'd0);
    check({nm, "_cs"}, 64'(bram_chipselect), 64'd0);
    check({nm, "_we"}, 64'(bram_write), 64'd0);
    check({nm, "_addr"}, 64'(bram_address), 64'd0);
  endtask

  typedef struct {
    int            m;
    bit            wr;
    logic [AW-1:0] addr;
    logic [CW-1:0] bc;
    logic [BW-1:0] be;
    int            n;
  } vec_t;

  vec_t vt [9];
  int   c0;
  int   bub_off [4];

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{0, 1'b1, 10'h010, 5'd3,  8'hFF, 3};   // preload for reads
    vt[1] = '{1, 1'b0, 10'h010, 5'd3,  8'hFF, 3};
    vt[2] = '{0, 1'b1, 10'h100, 5'd0,  8'hFF, 1};   // burstcount 0 -> 1 beat
    vt[3] = '{1, 1'b1, 10'h200, 5'd31, 8'hFF, 16};  // burstcount 31 -> 16
    vt[4] = '{0, 1'b0, 10'h200, 5'd31, 8'hFF, 16};
    vt[5] = '{1, 1'b1, 10'h010, 5'd1,  8'h0F, 1};   // partial byte lanes
    vt[6] = '{0, 1'b0, 10'h010, 5'd2,  8'hFF, 2};
    vt[7] = '{0, 1'b0, 10'h3FF, 5'd2,  8'hFF, 2};   // address wrap
    vt[8] = '{1, 1'b0, 10'h100, 5'd0,  8'hFF, 1};

    for (int m = 0; m < 2; m++) begin
      m_addr[m] = '0; m_bc[m] = '0; m_rd[m] = 0; m_wr[m] = 0; m_wd[m] = '0; m_be[m] = '0;
    end

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Single write across the address wrap, with timing and the m1 handshake
    acc_log.delete(); wlow1 = 0; c0 = cyc;
    exp_burst(0, 1, 10'h3FE, 4, 8'hFF, 1);
    master_burst(0, 1, 10'h3FE, 5'd4, 8'hFF, 4, 1, -1);
    drain("single_write");
    check("t1_nacc", 64'(acc_log.size()), 64'd4);
    for (int i = 0; i < acc_log.size(); i++)
      check("t1_cycle", 64'(acc_log[i]), 64'(c0 + 1 + i));
    check("t1_m1_wait_low", 64'(wlow1), 64'd0);

    for (int k = 0; k < 9; k++) begin
      exp_burst(vt[k].m, vt[k].wr, vt[k].addr, vt[k].n, vt[k].be, 100 + k);
      master_burst(vt[k].m, vt[k].wr, vt[k].addr, vt[k].bc, vt[k].be, vt[k].n, 100 + k, -1);
      drain($sformatf("vec%0d", k));
    end

    // Single read timing: readdatavalid is high at T+2..T+4
    rdv_log.delete(); c0 = cyc;
    exp_burst(1, 0, 10'h010, 3, 8'hFF, 0);
    master_burst(1, 0, 10'h010, 5'd3, 8'hFF, 3, 0, -1);
    drain("single_read");
    check("rd_nrdv", 64'(rdv_log.size()), 64'd3);
    for (int i = 0; i < rdv_log.size(); i++)
      check("rd_cycle", 64'(rdv_log[i]), 64'(c0 + 2 + i));

    // Write with one bubble: 4 beats over 5 cycles
    acc_log.delete(); c0 = cyc;
    bub_off = '{1, 3, 4, 5};
    exp_burst(0, 1, 10'h020, 4, 8'hFF, 20);
    master_burst(0, 1, 10'h020, 5'd4, 8'hFF, 4, 20, 1);
    drain("bubble");
    check("bub_nacc", 64'(acc_log.size()), 64'd4);
    for (int i = 0; i < acc_log.size() && i < 4; i++)
      check("bub_cycle", 64'(acc_log[i]), 64'(c0 + bub_off[i]));

    // Contention straight after reset, with each master re-requesting at once
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    exp_burst(0, 1, 10'h040, 2, 8'hFF, 30);
    exp_burst(0, 1, 10'h044, 2, 8'hFF, 32);
    exp_burst(1, 1, 10'h080, 2, 8'hFF, 31);
    exp_burst(1, 1, 10'h084, 2, 8'hFF, 33);
`else
    exp_burst(0, 1, 10'h040, 2, 8'hFF, 30);
    exp_burst(1, 1, 10'h080, 2, 8'hFF, 31);
    exp_burst(0, 1, 10'h044, 2, 8'hFF, 32);
    exp_burst(1, 1, 10'h084, 2, 8'hFF, 33);
`endif
    fork
      begin
        master_burst(0, 1, 10'h040, 5'd2, 8'hFF, 2, 30, -1);
        master_burst(0, 1, 10'h044, 5'd2, 8'hFF, 2, 32, -1);
      end
      begin
        master_burst(1, 1, 10'h080, 5'd2, 8'hFF, 2, 31, -1);
        master_burst(1, 1, 10'h084, 5'd2, 8'hFF, 2, 33, -1);
      end
    join
    drain("contention");

    // Reset during beat 2 of an 8-beat read
    exp_burst(0, 1, 10'h300, 8, 8'hFF, 40);
    master_burst(0, 1, 10'h300, 5'd8, 8'hFF, 8, 40, -1);
    drain("preload_300");
    exp_burst(1, 0, 10'h300, 2, 8'h00, 0);
    master_burst(1, 0, 10'h300, 5'd8, 8'h00, 8, 0, -1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    if (rdq1.size() > 0) void'(rdq1.pop_back());   // beat 2 is dropped
    check_idle("rst_mid");
    drain("rst_mid");
    exp_burst(1, 1, 10'h310, 2, 8'hFF, 41);
    master_burst(1, 1, 10'h310, 5'd2, 8'hFF, 2, 41, -1);
    drain("after_rst");
    exp_burst(0, 0, 10'h300, 2, 8'hFF, 0);
    master_burst(0, 0, 10'h300, 5'd2, 8'hFF, 2, 0, -1);
    drain("readback_300");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
